icache_linefill_ctrl: RTL
=========================

// Module: icache_linefill_ctrl
// PURPOSE
//  Downstream return stage of the icache miss path. Collects LINE_BEATS refill beats from downstream
//  for one outstanding MSHR entry, writes the full line to dataram and the new tag to tagram,
//  then pulses linefill_done to the owning MSHR entry. Handles one line at a time.
// PARAMETERS
//  MSHR_ENTRY_NUM      8    MSHR entries; rx txnid is the entry id
//  WAY_NUM             2    icache ways; way select is 1 bit
//  LINE_BEATS          4    beats per cache line (power of 2)
//  BEAT_WIDTH          128  data bits per beat
//  ICACHE_INDEX_WIDTH  6    set index width
//  ICACHE_TAG_WIDTH    20   tag width
// PORTS
//  clk              in   1                        clock
//  rst              in   1                        reset, asynchronous, active-high
//  rxdat_vld        in   1                        downstream refill beat valid
//  rxdat_rdy        out  1                        beat accepted when vld&rdy
//  rxdat_pld        in   linefill_rxdat_pld_t     {data[BEAT_WIDTH], txnid[$clog2(MSHR_ENTRY_NUM)], last}
//  mshr_index_vec   in   MSHR_ENTRY_NUM*IDX       per-entry set index, flattened
//  mshr_way_vec     in   MSHR_ENTRY_NUM           per-entry destination way
//  mshr_tag_vec     in   MSHR_ENTRY_NUM*TAG       per-entry tag, flattened
//  dataram_wr_vld   out  1                        full-line write request
//  dataram_wr_rdy   in   1
//  dataram_wr_pld   out  dataram_wr_pld_t         {way, index, data[LINE_BEATS*BEAT_WIDTH]}
//  tagram_wr_vld    out  1                        tag install request
//  tagram_wr_rdy    in   1
//  tagram_wr_pld    out  tagram_wr_pld_t          {way, index, tag, valid=1}
//  linefill_done    out  MSHR_ENTRY_NUM           one-hot, one-cycle pulse to owning entry
//  proto_err        out  1                        sticky protocol-violation flag
//  byp_vld/byp_rdy/byp_pld  out/in/out  1/1/{data,txnid,beat_idx}  only with ICACHE_LINEFILL_BYPASS_EN
// BEHAVIOUR
//  Reset: state=IDLE; rxdat_rdy=0 during reset, then 1; all *_vld=0; linefill_done=0; proto_err=0; beat_cnt=0.
//  FSM IDLE -> COLLECT -> WRITE -> DONE -> IDLE.
//   IDLE: rxdat_rdy=1; first accepted beat latches cur_txnid, stores beat 0, beat_cnt=1 -> COLLECT
//         (LINE_BEATS==1 or last on beat 0: see error rule).
//   COLLECT: rxdat_rdy=1; beat stored at slot beat_cnt, beat_cnt++ mod LINE_BEATS;
//            beat with beat_cnt==LINE_BEATS-1 -> WRITE.
//   WRITE: rxdat_rdy=0; data_sent/tag_sent flags start 0; dataram_wr_vld=~data_sent, tagram_wr_vld=~tag_sent;
//          each flag sets on its own vld&rdy; handshakes may complete same cycle or in either order;
//          -> DONE the cycle after both flags are set.
//   DONE: linefill_done[cur_txnid]=1 for exactly one cycle -> IDLE; rxdat_rdy=0 this cycle.
//  Latency: last beat accepted at T, both rdy high -> ram vlds at T+1, done pulse at T+2.
//  Index/way/tag sampled from the *_vec at cur_txnid when entering WRITE and held until IDLE.
//  Errors (set proto_err, sticky until reset):
//   - COLLECT beat with txnid!=cur_txnid: beat accepted and dropped; counter and buffer unchanged.
//   - last=1 on a non-final beat, or last=0 on final beat: line still completes on count; flag set.
//  Reset mid-operation: FSM to IDLE, buffer contents discarded, no done pulse, pending vlds drop.
//  Payloads held stable while vld=1 and rdy=0.
// CONFIGURATION
//  ICACHE_LINEFILL_BYPASS_EN defined: each accepted beat is also presented on byp_* (critical-word
//   forwarding to the fetch response). rxdat_rdy is additionally ANDed with byp_rdy in IDLE/COLLECT.
//   Beats dropped on txnid mismatch are not forwarded.
//  Undefined: byp_* ports absent; rxdat_rdy depends only on state.
// STRUCTURE
//  toy_pack: linefill_rxdat_pld_t, dataram_wr_pld_t, tagram_wr_pld_t, linefill_state_e, LINE_BEATS const.
//  Sub-module icache_line_buffer: LINE_BEATS x BEAT_WIDTH regs, write-enable+slot in, flat line out.
//  FSM, counter, handshake flags and error logic live in the top.
// TESTING
//  1. 4 beats txnid=3 back-to-back, rams rdy=1 -> dataram_wr_vld at T+1, linefill_done=8'b0000_1000 at T+2.
//  2. Data beats 0xA..0xD, dataram_wr_rdy low 5 cycles, tagram_wr_rdy=1 -> tag writes once, data held
//     stable, done one cycle after data handshake; line = {D,C,B,A}.
//  3. Beat 2 arrives with txnid=5 during txnid=1 line -> dropped, proto_err=1, line completes on 4 good beats.
//  4. last=1 on beat 1 -> proto_err=1, no early WRITE; done pulses after beat 3.
//  5. rst asserted after 2 beats -> outputs return to reset values asynchronously; next line completes cleanly.
//  6. (BYPASS_EN) byp_rdy=0 for 3 cycles -> rxdat_rdy=0 during those cycles, each beat forwarded exactly once.

Source files
------------

// File: rtl/icache_linefill_ctrl_pkg.sv
// rtl/icache_linefill_ctrl_pkg.sv - shared parameters, payload types and FSM states for the icache line-fill return stage
package icache_linefill_ctrl_pkg;

  localparam int MSHR_ENTRY_NUM     = 8;
  localparam int WAY_NUM            = 2;
  localparam int LINE_BEATS         = 4;
  localparam int BEAT_WIDTH         = 128;
  localparam int ICACHE_INDEX_WIDTH = 6;
  localparam int ICACHE_TAG_WIDTH   = 20;

  localparam int TXNID_W    = $clog2(MSHR_ENTRY_NUM);
  localparam int CNT_W      = (LINE_BEATS > 1) ? $clog2(LINE_BEATS) : 1;
  localparam int LINE_WIDTH = LINE_BEATS * BEAT_WIDTH;

  typedef struct packed {
    logic [BEAT_WIDTH-1:0] data;
    logic [TXNID_W-1:0]    txnid;
    logic                  last;
  } linefill_rxdat_pld_t;

  typedef struct packed {
    logic                          way;
    logic [ICACHE_INDEX_WIDTH-1:0] index;
    logic [LINE_WIDTH-1:0]         data;
  } dataram_wr_pld_t;

  typedef struct packed {
    logic                          way;
    logic [ICACHE_INDEX_WIDTH-1:0] index;
    logic [ICACHE_TAG_WIDTH-1:0]   tag;
    logic                          valid;
  } tagram_wr_pld_t;

  typedef struct packed {
    logic [BEAT_WIDTH-1:0] data;
    logic [TXNID_W-1:0]    txnid;
    logic [CNT_W-1:0]      beat_idx;
  } byp_pld_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_WRITE   = 2'd2,
    ST_DONE    = 2'd3
  } linefill_state_e;

endpackage

// File: rtl/icache_line_buffer.sv
// rtl/icache_line_buffer.sv - LINE_BEATS x BEAT_WIDTH refill staging buffer, beat 0 at the LSBs
module icache_line_buffer
  import icache_linefill_ctrl_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [CNT_W-1:0]      slot,
  input  logic [BEAT_WIDTH-1:0] wdata,
  output logic [LINE_WIDTH-1:0] line
);

  logic [LINE_WIDTH-1:0] line_q, line_d;

  // Overwrite only the addressed beat slot; other slots keep their contents.
  always_comb begin
    line_d = line_q;
    if (we) begin
      line_d[int'(slot)*BEAT_WIDTH +: BEAT_WIDTH] = wdata;
    end
  end

  // Buffer storage; cleared on reset so a half-collected line never leaks into the next one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      line_q <= '0;
    end else begin
      line_q <= line_d;
    end
  end

  assign line = line_q;

endmodule

// File: rtl/icache_linefill_ctrl.sv
// rtl/icache_linefill_ctrl.sv - collects refill beats, writes line+tag, pulses linefill_done; option ICACHE_LINEFILL_BYPASS_EN
module icache_linefill_ctrl
  import icache_linefill_ctrl_pkg::*;
(
  input  logic                                         clk,
  input  logic                                         rst,
  input  logic                                         rxdat_vld,
  output logic                                         rxdat_rdy,
  input  linefill_rxdat_pld_t                          rxdat_pld,
  input  logic [MSHR_ENTRY_NUM*ICACHE_INDEX_WIDTH-1:0] mshr_index_vec,
  input  logic [MSHR_ENTRY_NUM-1:0]                    mshr_way_vec,
  input  logic [MSHR_ENTRY_NUM*ICACHE_TAG_WIDTH-1:0]   mshr_tag_vec,
  output logic                                         dataram_wr_vld,
  input  logic                                         dataram_wr_rdy,
  output dataram_wr_pld_t                              dataram_wr_pld,
  output logic                                         tagram_wr_vld,
  input  logic                                         tagram_wr_rdy,
  output tagram_wr_pld_t                               tagram_wr_pld,
  output logic [MSHR_ENTRY_NUM-1:0]                    linefill_done,
  output logic                                         proto_err
`ifdef ICACHE_LINEFILL_BYPASS_EN
  ,
  output logic                                         byp_vld,
  input  logic                                         byp_rdy,
  output byp_pld_t                                     byp_pld
`endif
);

  linefill_state_e               state_q, state_d;
  logic [CNT_W-1:0]              beat_cnt_q, beat_cnt_d;
  logic [TXNID_W-1:0]            cur_txnid_q, cur_txnid_d;
  logic                          way_q, way_d;
  logic [ICACHE_INDEX_WIDTH-1:0] index_q, index_d;
  logic [ICACHE_TAG_WIDTH-1:0]   tag_q, tag_d;
  logic                          data_sent_q, data_sent_d;
  logic                          tag_sent_q, tag_sent_d;
  logic                          proto_err_q, proto_err_d;

  logic                  rdy_state;
  logic                  rx_fire;
  logic                  txnid_mismatch;
  logic                  beat_take;
  logic                  beat_is_final;
  logic                  buf_we;
  logic                  data_done;
  logic                  tag_done;
  logic [LINE_WIDTH-1:0] line_data;

  // Only IDLE and COLLECT take beats; reset forces rdy low while it is held.
  assign rdy_state      = (state_q == ST_IDLE) || (state_q == ST_COLLECT);
  assign txnid_mismatch = (state_q == ST_COLLECT) && (rxdat_pld.txnid != cur_txnid_q);
  assign beat_is_final  = (beat_cnt_q == CNT_W'(LINE_BEATS - 1));
  assign rx_fire        = rxdat_vld && rxdat_rdy;
  assign beat_take      = rx_fire && !txnid_mismatch;

`ifdef ICACHE_LINEFILL_BYPASS_EN
  // Forward each stored beat to the fetch path in the same cycle it is accepted.
  assign rxdat_rdy = rdy_state && !rst && byp_rdy;
  assign byp_vld   = rxdat_vld && rdy_state && !rst && !txnid_mismatch;
  assign byp_pld   = '{data: rxdat_pld.data, txnid: rxdat_pld.txnid, beat_idx: beat_cnt_q};
`else
  assign rxdat_rdy = rdy_state && !rst;
`endif

  icache_line_buffer u_line_buffer (
    .clk   (clk),
    .rst   (rst),
    .we    (buf_we),
    .slot  (beat_cnt_q),
    .wdata (rxdat_pld.data),
    .line  (line_data)
  );

  // Next-state, counter, handshake flags and error detection for the one in-flight line.
  always_comb begin
    state_d        = state_q;
    beat_cnt_d     = beat_cnt_q;
    cur_txnid_d    = cur_txnid_q;
    way_d          = way_q;
    index_d        = index_q;
    tag_d          = tag_q;
    data_sent_d    = data_sent_q;
    tag_sent_d     = tag_sent_q;
    proto_err_d    = proto_err_q;
    buf_we         = 1'b0;
    dataram_wr_vld = 1'b0;
    tagram_wr_vld  = 1'b0;
    data_done      = 1'b0;
    tag_done       = 1'b0;
    linefill_done  = '0;

    case (state_q)
      ST_IDLE, ST_COLLECT: begin
        // A foreign txnid mid-line is swallowed so it cannot stall the link.
        if (rx_fire && txnid_mismatch) begin
          proto_err_d = 1'b1;
        end
        if (beat_take) begin
          buf_we = 1'b1;
          if (state_q == ST_IDLE) begin
            cur_txnid_d = rxdat_pld.txnid;
          end
          // The line completes on beat count; a misplaced last flag is only reported.
          if (rxdat_pld.last != beat_is_final) begin
            proto_err_d = 1'b1;
          end
          if (beat_is_final) begin
            beat_cnt_d = '0;
            state_d    = ST_WRITE;
            way_d      = mshr_way_vec[rxdat_pld.txnid];
            index_d    = mshr_index_vec[int'(rxdat_pld.txnid)*ICACHE_INDEX_WIDTH +: ICACHE_INDEX_WIDTH];
            tag_d      = mshr_tag_vec[int'(rxdat_pld.txnid)*ICACHE_TAG_WIDTH +: ICACHE_TAG_WIDTH];
          end else begin
            beat_cnt_d = beat_cnt_q + 1'b1;
            state_d    = ST_COLLECT;
          end
        end
      end
      ST_WRITE: begin
        dataram_wr_vld = !data_sent_q;
        tagram_wr_vld  = !tag_sent_q;
        data_done      = data_sent_q || (dataram_wr_vld && dataram_wr_rdy);
        tag_done       = tag_sent_q || (tagram_wr_vld && tagram_wr_rdy);
        if (data_done && tag_done) begin
          state_d     = ST_DONE;
          data_sent_d = 1'b0;
          tag_sent_d  = 1'b0;
        end else begin
          data_sent_d = data_done;
          tag_sent_d  = tag_done;
        end
      end
      ST_DONE: begin
        linefill_done[cur_txnid_q] = 1'b1;
        state_d                    = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers; reset abandons any partially collected or pending line.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      beat_cnt_q  <= '0;
      cur_txnid_q <= '0;
      way_q       <= 1'b0;
      index_q     <= '0;
      tag_q       <= '0;
      data_sent_q <= 1'b0;
      tag_sent_q  <= 1'b0;
      proto_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      beat_cnt_q  <= beat_cnt_d;
      cur_txnid_q <= cur_txnid_d;
      way_q       <= way_d;
      index_q     <= index_d;
      tag_q       <= tag_d;
      data_sent_q <= data_sent_d;
      tag_sent_q  <= tag_sent_d;
      proto_err_q <= proto_err_d;
    end
  end

  assign dataram_wr_pld = '{way: way_q, index: index_q, data: line_data};
  assign tagram_wr_pld  = '{way: way_q, index: index_q, tag: tag_q, valid: 1'b1};
  assign proto_err      = proto_err_q;

endmodule
